stack_controller: RTL and testbench
===================================

# stack_controller

Sequencer and arbiter for the memory-stage stack. Owns the stack pointer register and executes single-word and multi-word stack operations (PUSH/POP/CALL/RET, interrupt entry, RTI) as a sequence of one-word memory accesses. Arbitrates between the pipeline's stack request and the interrupt unit's entry request. Stalls the pipeline while a sequence is in flight.

## Interface
- SP_TOP, 32'h0000_0FFF: SP reset value; stack empty when SP == SP_TOP.
- SP_LIMIT, 32'h0000_0800: lowest legal stack address; used only with bounds checking.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  pipeline stack request; held until op_ack
- op_code  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 RTI (others treated as NOP)
- push_data  in  16  word for PUSH
- pc_in  in  32  return PC for CALL / interrupt entry
- flags_in  in  3  CCR saved on interrupt entry
- int_req  in  1  interrupt entry request; held until int_ack
- mem_rdata  in  16  data memory read data, combinational in the same cycle as mem_re
- op_ack / int_ack  out  1  one-cycle acceptance pulses
- mem_addr  out  32  stack access address
- mem_we / mem_re  out  1  memory write / read strobes
- mem_wdata  out  16  write data
- stall  out  1  high while busy
- done  out  1  one-cycle pulse on the final word of a sequence
- pop_data  out  16  result of POP
- pc_out  out  32  PC restored by RET/RTI
- flags_out  out  3  CCR restored by RTI
- sp_out  out  32  current SP
- fault  out  1  bounds violation pulse (present only with STACK_BOUNDS_CHECK_EN)

## Operation
- Push = pre-decrement: address SP-1, SP <= SP-1. Pop = post-increment: address SP, SP <= SP+1. Arithmetic modulo 2^32.
- Word sequences (k = word count):
  - PUSH k=1: push_data.
  - POP k=1: pop_data.
  - CALL k=2: pc[31:16], then pc[15:0].
  - RET k=2: pc[15:0], then pc[31:16].
  - INT k=3: pc[31:16], pc[15:0], then {13'b0, flags}.
  - RTI k=3: flags (bits [2:0]), pc[15:0], then pc[31:16].
- Operands are latched at acceptance; inputs are ignored afterwards.
- FSM states:
  - IDLE: accepts a request.
  - BUSY: word counter runs k-1 down to 0; returns to IDLE after the last word.
- Arbitration in IDLE: int_req wins over op_valid; the losing op_valid stays pending. NOP is acked and completes with no access and no done pulse.
- op_valid and int_req are not sampled in BUSY.
- Strobes:
  - mem_we/mem_re are asserted only in BUSY, one per cycle.
  - mem_addr, mem_wdata and mem_we/mem_re are zero when not in use.

## Timing
- Reset values:
  - SP = SP_TOP; state IDLE.
  - All strobes, acks, done, stall and fault = 0.
  - pop_data, pc_out, flags_out = 0.
- Accept in cycle N (IDLE, ack pulses). Words occupy cycles N+1..N+k; done pulses in N+k.
- SP updates at the end of each word cycle.
- pop_data/pc_out/flags_out are registered and valid from N+k+1; they hold until the next sequence writes them.
- stall = (state == BUSY); the pipeline is held for exactly k cycles.
- Back-to-back: a new request can be accepted in cycle N+k+1.
- rst in any state aborts the sequence: IDLE, SP = SP_TOP. A partially pushed frame is discarded and no done is issued.

## Configuration
- STACK_BOUNDS_CHECK_EN defined:
  - At acceptance, push ops with SP - k < SP_LIMIT are rejected, and pop ops with SP + k > SP_TOP are rejected.
  - Rejection: ack still pulses, fault pulses in cycle N+1, no memory access, SP unchanged, no done, stall stays low.
- Undefined: no fault port, no checks, SP wraps silently.

## Structure
- Package stack_ctrl_pkg holds:
  - op_code encodings
  - FSM state encoding
  - per-op word counts and direction (push/pop)
  - MEM_W = 16
- Sub-module stack_addr_gen (combinational): from SP and the push/pop flag, produces the access address and next SP.
- The controller instantiates stack_addr_gen once.

## Test plan
- Reset, then PUSH 16'hABCD: write at 0x0FFE, SP = 0x0FFE, done at N+1; then POP: read 0x0FFE, pop_data = 16'hABCD, SP = 0x0FFF.
- CALL with pc_in 0x0001_0200, then RET: writes 0x0001 @0x0FFE and 0x0200 @0x0FFD; RET gives pc_out = 0x0001_0200 and SP back to 0x0FFF; stall is 2 cycles each.
- int_req and op_valid (PUSH) in the same cycle with pc 0x0000_0040, flags 3'b101:
  - int_ack first; three writes (0x0000, 0x0040, 0x0005) at 0x0FFE..0x0FFC.
  - PUSH is acked at N+4.
  - RTI then restores flags 3'b101 and pc 0x0000_0040.
- rst asserted in the second word of CALL: the next cycle shows IDLE, SP = 0x0FFF, no done, no further mem_we.
- With STACK_BOUNDS_CHECK_EN, POP at SP = SP_TOP: fault pulses, no mem_re, SP unchanged. Without the macro: read at 0x0FFF, SP = 0x1000.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the memory-stage stack controller: operation
// encodings, FSM states, stack bounds and per-operation word counts.
package stack_ctrl_pkg;

    localparam int          MEM_W    = 16;
    localparam logic [31:0] SP_TOP   = 32'h0000_0FFF;
    localparam logic [31:0] SP_LIMIT = 32'h0000_0800;

    // Pipeline codes 0..5 map one-to-one; OP_INT is internal only and
    // marks an interrupt-entry sequence (codes 6/7 from the pipeline are NOPs).
    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_RTI  = 3'd5,
        OP_INT  = 3'd6
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic op_e decode_op(input logic [2:0] code);
        case (code)
            3'd1:    return OP_PUSH;
            3'd2:    return OP_POP;
            3'd3:    return OP_CALL;
            3'd4:    return OP_RET;
            3'd5:    return OP_RTI;
            default: return OP_NOP;
        endcase
    endfunction

    function automatic logic [1:0] op_words(input op_e op);
        case (op)
            OP_PUSH, OP_POP: return 2'd1;
            OP_CALL, OP_RET: return 2'd2;
            OP_INT,  OP_RTI: return 2'd3;
            default:         return 2'd0;
        endcase
    endfunction

    function automatic logic op_is_push(input op_e op);
        return (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
    endfunction

endpackage

// File: rtl/stack_controller_if.sv
// Bundle of pipeline, interrupt and data-memory signals around the stack
// controller. master = pipeline/interrupt/memory side, slave = controller.
interface stack_controller_if;
    import stack_ctrl_pkg::*;

    logic             op_valid;
    logic [2:0]       op_code;
    logic [MEM_W-1:0] push_data;
    logic [31:0]      pc_in;
    logic [2:0]       flags_in;
    logic             int_req;
    logic [MEM_W-1:0] mem_rdata;

    logic             op_ack;
    logic             int_ack;
    logic [31:0]      mem_addr;
    logic             mem_we;
    logic             mem_re;
    logic [MEM_W-1:0] mem_wdata;
    logic             stall;
    logic             done;
    logic [MEM_W-1:0] pop_data;
    logic [31:0]      pc_out;
    logic [2:0]       flags_out;
    logic [31:0]      sp_out;
`ifdef STACK_BOUNDS_CHECK_EN
    logic             fault;
`endif

    modport master (
`ifdef STACK_BOUNDS_CHECK_EN
        input  fault,
`endif
        output op_valid, op_code, push_data, pc_in, flags_in, int_req, mem_rdata,
        input  op_ack, int_ack, mem_addr, mem_we, mem_re, mem_wdata,
        input  stall, done, pop_data, pc_out, flags_out, sp_out
    );

    modport slave (
`ifdef STACK_BOUNDS_CHECK_EN
        output fault,
`endif
        input  op_valid, op_code, push_data, pc_in, flags_in, int_req, mem_rdata,
        output op_ack, int_ack, mem_addr, mem_we, mem_re, mem_wdata,
        output stall, done, pop_data, pc_out, flags_out, sp_out
    );

endinterface

// File: rtl/stack_addr_gen.sv
// Stack address generator: pre-decrement for pushes, post-increment for
// pops, both modulo 2^32.
module stack_addr_gen (
    input  logic [31:0] sp,
    input  logic        push,
    output logic [31:0] addr,
    output logic [31:0] next_sp
);

    assign addr    = push ? (sp - 32'd1) : sp;
    assign next_sp = push ? (sp - 32'd1) : (sp + 32'd1);

endmodule

// File: rtl/stack_controller.sv
// Stack sequencer/arbiter: owns SP, runs PUSH/POP/CALL/RET/RTI and interrupt
// entry as one-word memory accesses, stalling the pipeline while busy.
// Optional feature: define STACK_BOUNDS_CHECK_EN for SP bounds checking and
// the fault pulse output.
module stack_controller
    import stack_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    stack_controller_if.slave  bus
);

    state_e           state, next_state;
    op_e              cur_op, req_op;
    logic [1:0]       cnt;
    logic [31:0]      sp, acc_addr, next_sp;
    logic [MEM_W-1:0] push_q, wr_word, pop_q;
    logic [31:0]      pc_q, pc_out_q;
    logic [2:0]       flags_q, flags_out_q;
    logic             req_any, reject, start, active, cur_push;

    assign cur_push = op_is_push(cur_op);

    stack_addr_gen u_addr_gen (
        .sp      (sp),
        .push    (cur_push),
        .addr    (acc_addr),
        .next_sp (next_sp)
    );

    // Arbitration in IDLE: interrupt entry beats the pipeline request.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        req_any = (state == ST_IDLE) && !rst && (bus.int_req || bus.op_valid);
        req_op  = bus.int_req ? OP_INT : decode_op(bus.op_code);
        reject  = 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
        if (op_is_push(req_op))
            reject = (sp < (SP_LIMIT + {30'd0, op_words(req_op)}));
        else if (req_op != OP_NOP)
            reject = (({1'b0, sp} + {31'd0, op_words(req_op)}) > {1'b0, SP_TOP});
`endif
        start = req_any && (req_op != OP_NOP) && !reject;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // FSM next state: leave IDLE on a real accepted op, return after word 0.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start)       next_state = ST_BUSY;
            ST_BUSY: if (cnt == 2'd0) next_state = ST_IDLE;
            default:                  next_state = ST_IDLE;
        endcase
    end

    // Word to write for the current step of a push-type sequence.
    always_comb begin
        wr_word = '0;
        case (cur_op)
            OP_PUSH: wr_word = push_q;
            OP_CALL: wr_word = (cnt == 2'd1) ? pc_q[31:16] : pc_q[15:0];
            OP_INT: begin
                case (cnt)
                    2'd2:    wr_word = pc_q[31:16];
                    2'd1:    wr_word = pc_q[15:0];
                    default: wr_word = {13'd0, flags_q};
                endcase
            end
            default: wr_word = '0;
        endcase
    end

    // FSM outputs: acks in IDLE, strobes/done in BUSY, all forced low by rst.
    always_comb begin
        active        = (state == ST_BUSY) && !rst;
        bus.op_ack    = (state == ST_IDLE) && !rst && bus.op_valid && !bus.int_req;
        bus.int_ack   = (state == ST_IDLE) && !rst && bus.int_req;
        bus.stall     = (state == ST_BUSY);
        bus.done      = active && (cnt == 2'd0);
        bus.mem_we    = active && cur_push;
        bus.mem_re    = active && !cur_push;
        bus.mem_addr  = active ? acc_addr : 32'd0;
        bus.mem_wdata = (active && cur_push) ? wr_word : '0;
    end

    // Operand latch at acceptance, SP step and read-data capture per word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp          <= SP_TOP;
            cnt         <= 2'd0;
            cur_op      <= OP_NOP;
            push_q      <= '0;
            pc_q        <= '0;
            flags_q     <= '0;
            pop_q       <= '0;
            pc_out_q    <= '0;
            flags_out_q <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                cur_op  <= req_op;
                cnt     <= op_words(req_op) - 2'd1;
                push_q  <= bus.push_data;
                pc_q    <= bus.pc_in;
                flags_q <= bus.flags_in;
            end
        end else begin
            sp  <= next_sp;
            cnt <= cnt - 2'd1;
            case (cur_op)
                OP_POP: pop_q <= bus.mem_rdata;
                OP_RET: begin
                    if (cnt == 2'd1) pc_out_q[15:0]  <= bus.mem_rdata;
                    else             pc_out_q[31:16] <= bus.mem_rdata;
                end
                OP_RTI: begin
                    case (cnt)
                        2'd2:    flags_out_q     <= bus.mem_rdata[2:0];
                        2'd1:    pc_out_q[15:0]  <= bus.mem_rdata;
                        default: pc_out_q[31:16] <= bus.mem_rdata;
                    endcase
                end
                default: ;
            endcase
        end
    end

`ifdef STACK_BOUNDS_CHECK_EN
    logic fault_q;

    // Fault pulses the cycle after a rejected acceptance.
    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= req_any && reject;
    end

    assign bus.fault = fault_q;
`endif

    assign bus.sp_out    = sp;
    assign bus.pop_data  = pop_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.flags_out = flags_out_q;

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: table of single operations,
// plus hand sequences for arbitration, mid-sequence reset and the
// SP_TOP pop boundary (with or without STACK_BOUNDS_CHECK_EN).
module tb_stack_controller;
    import stack_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;

    always #5 clk = ~clk;

    stack_controller_if sif();

    stack_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    // Data memory model: unwritten words read back as an address signature.
    logic [15:0] tb_mem  [0:8191];
    logic        written [0:8191];
    logic [12:0] mem_idx;

    assign mem_idx       = sif.mem_addr[12:0];
    assign sif.mem_rdata = !sif.mem_re ? 16'h0000 :
                           (written[mem_idx] ? tb_mem[mem_idx] : (16'h5A5A ^ {3'b000, mem_idx}));

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8192; i++) written[i] <= 1'b0;
        end else if (sif.mem_we) begin
            tb_mem[mem_idx]  <= sif.mem_wdata;
            written[mem_idx] <= 1'b1;
        end
    end

    typedef struct {
        logic        is_int;
        logic [2:0]  code;
        logic [15:0] d;
        logic [31:0] pc;
        logic [2:0]  fl;
        int          k;
        logic [31:0] exp_sp;
        logic [15:0] exp_pop;
        logic [31:0] exp_pc;
        logic [2:0]  exp_fl;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [15:0] data;
    } acc_t;

    acc_t        acc_q[$];
    logic [31:0] m_sp;
    int          n_cmp;
    int          n_err;
    string       cur_tag;
    vec_t        vecs[12];

    function automatic vec_t mk(input logic is_int, input logic [2:0] code,
                                input logic [15:0] d, input logic [31:0] pc,
                                input logic [2:0] fl, input int k,
                                input logic [31:0] exp_sp, input logic [15:0] exp_pop,
                                input logic [31:0] exp_pc, input logic [2:0] exp_fl);
        vec_t v;
        v.is_int = is_int; v.code = code; v.d = d; v.pc = pc; v.fl = fl; v.k = k;
        v.exp_sp = exp_sp; v.exp_pop = exp_pop; v.exp_pc = exp_pc; v.exp_fl = exp_fl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got 0x%08h, expected 0x%08h", cur_tag, name, act, exp);
        end
    endtask

    // Advance to the next falling edge and score any memory access seen there.
    task automatic tick();
        acc_t a;
        @(negedge clk);
        if (sif.mem_we || sif.mem_re) begin
            if (acc_q.size() == 0) begin
                check("pending_access", 32'(acc_q.size()), 32'd1);
            end else begin
                a = acc_q.pop_front();
                check("mem_we", 32'(sif.mem_we), 32'(a.we));
                check("mem_addr", sif.mem_addr, a.addr);
                if (a.we) check("mem_wdata", 32'(sif.mem_wdata), 32'(a.data));
            end
        end
    endtask

    task automatic exp_wr(input logic [15:0] w);
        acc_t a;
        m_sp   = m_sp - 32'd1;
        a.we   = 1'b1;
        a.addr = m_sp;
        a.data = w;
        acc_q.push_back(a);
    endtask

    task automatic exp_rd();
        acc_t a;
        a.we   = 1'b0;
        a.addr = m_sp;
        a.data = 16'h0000;
        acc_q.push_back(a);
        m_sp   = m_sp + 32'd1;
    endtask

    // Expected access sequence for an accepted operation.
    task automatic exp_seq(input logic is_int, input logic [2:0] code, input logic [15:0] d,
                           input logic [31:0] pc, input logic [2:0] fl);
        if (is_int) begin
            exp_wr(pc[31:16]); exp_wr(pc[15:0]); exp_wr({13'd0, fl});
        end else begin
            case (code)
                3'd1: exp_wr(d);
                3'd2: exp_rd();
                3'd3: begin exp_wr(pc[31:16]); exp_wr(pc[15:0]); end
                3'd4: begin exp_rd(); exp_rd(); end
                3'd5: begin exp_rd(); exp_rd(); exp_rd(); end
                default: ;
            endcase
        end
    endtask

    task automatic drive_req(input logic is_int, input logic [2:0] code, input logic [15:0] d,
                             input logic [31:0] pc, input logic [2:0] fl);
        @(posedge clk);
        #1;
        sif.int_req   = is_int;
        sif.op_valid  = !is_int;
        sif.op_code   = code;
        sif.push_data = d;
        sif.pc_in     = pc;
        sif.flags_in  = fl;
    endtask

    // Drop requests and garble operands so late sampling would show up.
    task automatic scramble();
        @(posedge clk);
        #1;
        sif.int_req   = 1'b0;
        sif.op_valid  = 1'b0;
        sif.op_code   = 3'd1;
        sif.push_data = 16'hFFFF;
        sif.pc_in     = 32'hFFFF_FFFF;
        sif.flags_in  = 3'b111;
    endtask

    task automatic run_vec(input vec_t v);
        int w;
        drive_req(v.is_int, v.code, v.d, v.pc, v.fl);
        tick();
        w = 0;
        while (!(v.is_int ? sif.int_ack : sif.op_ack) && w < 10) begin
            tick();
            w++;
        end
        check("ack", 32'(v.is_int ? sif.int_ack : sif.op_ack), 32'd1);
        exp_seq(v.is_int, v.code, v.d, v.pc, v.fl);
        scramble();
        for (int i = 1; i <= v.k; i++) begin
            tick();
            check("stall_busy", 32'(sif.stall), 32'd1);
            check("done", 32'(sif.done), 32'(i == v.k));
        end
        tick();
        check("stall_after", 32'(sif.stall), 32'd0);
        check("done_after", 32'(sif.done), 32'd0);
        check("sp_out", sif.sp_out, v.exp_sp);
        check("pop_data", 32'(sif.pop_data), 32'(v.exp_pop));
        check("pc_out", sif.pc_out, v.exp_pc);
        check("flags_out", 32'(sif.flags_out), 32'(v.exp_fl));
        check("scoreboard_empty", 32'(acc_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_sp  = SP_TOP;
        cur_tag = "reset";
        rst = 1'b1;
        mem_clr = 1'b1;
        sif.int_req = 1'b0; sif.op_valid = 1'b0; sif.op_code = 3'd0;
        sif.push_data = 16'h0; sif.pc_in = 32'h0; sif.flags_in = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_clr = 1'b0;

        tick();
        check("sp", sif.sp_out, 32'h0000_0FFF);
        check("stall", 32'(sif.stall), 32'd0);
        check("done", 32'(sif.done), 32'd0);
        check("op_ack", 32'(sif.op_ack), 32'd0);
        check("int_ack", 32'(sif.int_ack), 32'd0);
        check("mem_we", 32'(sif.mem_we), 32'd0);
        check("mem_re", 32'(sif.mem_re), 32'd0);
        check("mem_addr", sif.mem_addr, 32'd0);
        check("pop_data", 32'(sif.pop_data), 32'd0);
        check("pc_out", sif.pc_out, 32'd0);
        check("flags_out", 32'(sif.flags_out), 32'd0);
`ifdef STACK_BOUNDS_CHECK_EN
        check("fault", 32'(sif.fault), 32'd0);
`endif

        //            int code data      pc            fl    k  sp            pop       pc            fl
        vecs[0]  = mk(0, 3'd1, 16'hABCD, 32'h0,        3'd0, 1, 32'h0000_0FFE, 16'h0000, 32'h0,        3'd0);
        vecs[1]  = mk(0, 3'd2, 16'h0,    32'h0,        3'd0, 1, 32'h0000_0FFF, 16'hABCD, 32'h0,        3'd0);
        vecs[2]  = mk(0, 3'd3, 16'h0,    32'h0001_0200,3'd0, 2, 32'h0000_0FFD, 16'hABCD, 32'h0,        3'd0);
        vecs[3]  = mk(0, 3'd4, 16'h0,    32'h0,        3'd0, 2, 32'h0000_0FFF, 16'hABCD, 32'h0001_0200,3'd0);
        vecs[4]  = mk(0, 3'd1, 16'h1234, 32'h0,        3'd0, 1, 32'h0000_0FFE, 16'hABCD, 32'h0001_0200,3'd0);
        vecs[5]  = mk(0, 3'd1, 16'h5678, 32'h0,        3'd0, 1, 32'h0000_0FFD, 16'hABCD, 32'h0001_0200,3'd0);
        vecs[6]  = mk(0, 3'd2, 16'h0,    32'h0,        3'd0, 1, 32'h0000_0FFE, 16'h5678, 32'h0001_0200,3'd0);
        vecs[7]  = mk(0, 3'd2, 16'h0,    32'h0,        3'd0, 1, 32'h0000_0FFF, 16'h1234, 32'h0001_0200,3'd0);
        vecs[8]  = mk(0, 3'd0, 16'h0,    32'h0,        3'd0, 0, 32'h0000_0FFF, 16'h1234, 32'h0001_0200,3'd0);
        vecs[9]  = mk(0, 3'd7, 16'h0,    32'h0,        3'd0, 0, 32'h0000_0FFF, 16'h1234, 32'h0001_0200,3'd0);
        vecs[10] = mk(1, 3'd0, 16'h0,    32'hDEAD_BEEF,3'd3, 3, 32'h0000_0FFC, 16'h1234, 32'h0001_0200,3'd0);
        vecs[11] = mk(0, 3'd5, 16'h0,    32'h0,        3'd0, 3, 32'h0000_0FFF, 16'h1234, 32'hDEAD_BEEF,3'd3);

        for (int i = 0; i < 12; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            run_vec(vecs[i]);
        end

        // Interrupt and PUSH requested together; PUSH stays pending.
        cur_tag = "int_vs_push";
        drive_req(1'b0, 3'd1, 16'h7777, 32'h0000_0040, 3'b101);
        sif.int_req = 1'b1;
        tick();
        check("int_ack", 32'(sif.int_ack), 32'd1);
        check("op_ack_lost", 32'(sif.op_ack), 32'd0);
        exp_seq(1'b1, 3'd0, 16'h0, 32'h0000_0040, 3'b101);
        @(posedge clk);
        #1;
        sif.int_req  = 1'b0;
        sif.pc_in    = 32'hFFFF_FFFF;
        sif.flags_in = 3'b000;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("stall_busy", 32'(sif.stall), 32'd1);
            check("op_ack_busy", 32'(sif.op_ack), 32'd0);
            check("done", 32'(sif.done), 32'(i == 3));
        end
        tick();
        check("push_ack_n4", 32'(sif.op_ack), 32'd1);
        check("int_ack_n4", 32'(sif.int_ack), 32'd0);
        check("stall_n4", 32'(sif.stall), 32'd0);
        exp_seq(1'b0, 3'd1, 16'h7777, 32'h0, 3'b000);
        scramble();
        tick();
        check("stall_push", 32'(sif.stall), 32'd1);
        check("done_push", 32'(sif.done), 32'd1);
        tick();
        check("stall_after", 32'(sif.stall), 32'd0);
        check("sp_out", sif.sp_out, 32'h0000_0FFB);
        check("scoreboard_empty", 32'(acc_q.size()), 32'd0);
        cur_tag = "int_pop";
        run_vec(mk(0, 3'd2, 16'h0, 32'h0, 3'd0, 1, 32'h0000_0FFC, 16'h7777, 32'hDEAD_BEEF, 3'd3));
        cur_tag = "int_rti";
        run_vec(mk(0, 3'd5, 16'h0, 32'h0, 3'd0, 3, 32'h0000_0FFF, 16'h7777, 32'h0000_0040, 3'b101));

        // Reset during the second word of CALL.
        cur_tag = "rst_mid_call";
        drive_req(1'b0, 3'd3, 16'h0, 32'h0001_0200, 3'd0);
        tick();
        check("op_ack", 32'(sif.op_ack), 32'd1);
        exp_wr(16'h0001);
        scramble();
        tick();
        check("stall_w1", 32'(sif.stall), 32'd1);
        check("done_w1", 32'(sif.done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("done_rst", 32'(sif.done), 32'd0);
        check("mem_we_rst", 32'(sif.mem_we), 32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_sp = SP_TOP;
        tick();
        check("stall_idle", 32'(sif.stall), 32'd0);
        check("done_idle", 32'(sif.done), 32'd0);
        check("sp_top", sif.sp_out, 32'h0000_0FFF);
        check("pop_cleared", 32'(sif.pop_data), 32'd0);
        check("pc_cleared", sif.pc_out, 32'd0);
        check("flags_cleared", 32'(sif.flags_out), 32'd0);
        check("scoreboard_empty", 32'(acc_q.size()), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("mem_we_quiet", 32'(sif.mem_we), 32'd0);
        end

        // POP at SP_TOP.
        cur_tag = "pop_at_top";
`ifdef STACK_BOUNDS_CHECK_EN
        drive_req(1'b0, 3'd2, 16'h0, 32'h0, 3'd0);
        tick();
        check("op_ack", 32'(sif.op_ack), 32'd1);
        scramble();
        tick();
        check("fault_n1", 32'(sif.fault), 32'd1);
        check("stall_n1", 32'(sif.stall), 32'd0);
        check("mem_re_n1", 32'(sif.mem_re), 32'd0);
        tick();
        check("fault_n2", 32'(sif.fault), 32'd0);
        check("done_n2", 32'(sif.done), 32'd0);
        check("sp_kept", sif.sp_out, 32'h0000_0FFF);
        check("scoreboard_empty", 32'(acc_q.size()), 32'd0);
`else
        run_vec(mk(0, 3'd2, 16'h0, 32'h0, 3'd0, 1, 32'h0000_1000, 16'h55A5, 32'h0, 3'd0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
